// File: rtl/dcache_miss_ctrl.sv
// Data-cache miss sequencer: stalls the MEM stage on a miss, writes back a dirty victim,
// refills the requested line with fixed memory latency and keeps saturating statistics.
module dcache_miss_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int OFFSET_BITS = 4,
  parameter int MEM_LATENCY = 3,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  input  logic                  hit_i,
  input  logic                  victim_dirty_i,
  input  logic [DATA_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] victim_addr_i,
  output logic                  stall_o,
  output logic                  mem_wr_en_o,
  output logic                  mem_rd_en_o,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  output logic                  refill_en_o,
  output logic                  busy_o,
  output logic [CNT_WIDTH-1:0]  miss_count_o,
  output logic [CNT_WIDTH-1:0]  wb_count_o
);

  localparam int CW = $clog2(MEM_LATENCY + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(MEM_LATENCY - 1);
  localparam logic [DATA_WIDTH-1:0] LINE_MASK =
    {{(DATA_WIDTH-OFFSET_BITS){1'b1}}, {OFFSET_BITS{1'b0}}};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WRITEBACK = 2'd1,
    S_REFILL    = 2'd2,
    S_DONE      = 2'd3
  } state_t;

  function automatic logic [DATA_WIDTH-1:0] line_align(input logic [DATA_WIDTH-1:0] a);
    return a & LINE_MASK;
  endfunction

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   req_addr_q, req_addr_d;
  logic [DATA_WIDTH-1:0]   victim_addr_q, victim_addr_d;
  logic [CNT_WIDTH-1:0]    miss_cnt_q, miss_cnt_d;
  logic [CNT_WIDTH-1:0]    wb_cnt_q, wb_cnt_d;
  logic                    seq_stall_q, mem_wr_en_q, mem_rd_en_q, refill_en_q, busy_q;
  logic [DATA_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic                    miss_s, last_s, miss_inc_s, wb_inc_s;

  assign miss_s     = req_valid_i & ~hit_i;
  assign last_s     = (cnt_q == LAST_CNT);
  assign miss_inc_s = (state_q == S_IDLE) & miss_s;
  assign wb_inc_s   = (state_q == S_WRITEBACK) & (cnt_q == {CW{1'b0}});

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    req_addr_d    = req_addr_q;
    victim_addr_d = victim_addr_q;
    case (state_q)
      S_IDLE: begin
        if (miss_s) begin
          req_addr_d    = req_addr_i;
          victim_addr_d = victim_addr_i;
          cnt_d         = {CW{1'b0}};
          state_d       = victim_dirty_i ? S_WRITEBACK : S_REFILL;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WRITEBACK: begin
        if (last_s) begin
          cnt_d   = {CW{1'b0}};
          state_d = S_REFILL;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_REFILL: begin
        if (last_s) begin
          cnt_d   = {CW{1'b0}};
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    case (state_d)
      S_WRITEBACK: mem_addr_d = line_align(victim_addr_d);
      S_REFILL:    mem_addr_d = line_align(req_addr_d);
      default:     mem_addr_d = {DATA_WIDTH{1'b0}};
    endcase

    miss_cnt_d = (miss_inc_s && (miss_cnt_q != CNT_MAX)) ? miss_cnt_q + CNT_WIDTH'(1) : miss_cnt_q;
    wb_cnt_d   = (wb_inc_s && (wb_cnt_q != CNT_MAX)) ? wb_cnt_q + CNT_WIDTH'(1) : wb_cnt_q;
  end

  // Strobes are registered from the next state so they line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= {CW{1'b0}};
      req_addr_q    <= {DATA_WIDTH{1'b0}};
      victim_addr_q <= {DATA_WIDTH{1'b0}};
      miss_cnt_q    <= {CNT_WIDTH{1'b0}};
      wb_cnt_q      <= {CNT_WIDTH{1'b0}};
      seq_stall_q   <= 1'b0;
      mem_wr_en_q   <= 1'b0;
      mem_rd_en_q   <= 1'b0;
      refill_en_q   <= 1'b0;
      busy_q        <= 1'b0;
      mem_addr_q    <= {DATA_WIDTH{1'b0}};
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      req_addr_q    <= req_addr_d;
      victim_addr_q <= victim_addr_d;
      miss_cnt_q    <= miss_cnt_d;
      wb_cnt_q      <= wb_cnt_d;
      seq_stall_q   <= (state_d == S_WRITEBACK) || (state_d == S_REFILL);
      mem_wr_en_q   <= (state_d == S_WRITEBACK) && (cnt_d == {CW{1'b0}});
      mem_rd_en_q   <= (state_d == S_REFILL);
      refill_en_q   <= (state_d == S_REFILL) && (cnt_d == LAST_CNT);
      busy_q        <= (state_d != S_IDLE);
      mem_addr_q    <= mem_addr_d;
    end
  end

  // Reset silences stall and strobes already in the cycle it is asserted.
  assign stall_o      = ~rst & (seq_stall_q | miss_inc_s);
  assign mem_wr_en_o  = ~rst & mem_wr_en_q;
  assign mem_rd_en_o  = ~rst & mem_rd_en_q;
  assign refill_en_o  = ~rst & refill_en_q;
  assign mem_addr_o   = mem_addr_q;
  assign busy_o       = busy_q;
  assign miss_count_o = miss_cnt_q;
  assign wb_count_o   = wb_cnt_q;

endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// Directed-vector bench for dcache_miss_ctrl: a cycle table on the default instance plus
// hand sequences on a narrow-counter, single-cycle-latency instance.
module tb_dcache_miss_ctrl;

  logic        clk = 1'b0;
  logic        rst, req_valid, hit, victim_dirty;
  logic [31:0] req_addr, victim_addr;
  logic        stall, mem_wr_en, mem_rd_en, refill_en, busy;
  logic [31:0] mem_addr, miss_count, wb_count;

  logic        v2, h2, d2;
  logic [31:0] ra2, va2;
  logic        stall2, wr2, rd2, rf2, busy2;
  logic [31:0] ma2;
  logic [1:0]  mc2, wc2;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dcache_miss_ctrl dut (
    .clk(clk), .rst(rst), .req_valid_i(req_valid), .hit_i(hit),
    .victim_dirty_i(victim_dirty), .req_addr_i(req_addr), .victim_addr_i(victim_addr),
    .stall_o(stall), .mem_wr_en_o(mem_wr_en), .mem_rd_en_o(mem_rd_en),
    .mem_addr_o(mem_addr), .refill_en_o(refill_en), .busy_o(busy),
    .miss_count_o(miss_count), .wb_count_o(wb_count)
  );

  dcache_miss_ctrl #(.MEM_LATENCY(1), .CNT_WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .req_valid_i(v2), .hit_i(h2),
    .victim_dirty_i(d2), .req_addr_i(ra2), .victim_addr_i(va2),
    .stall_o(stall2), .mem_wr_en_o(wr2), .mem_rd_en_o(rd2),
    .mem_addr_o(ma2), .refill_en_o(rf2), .busy_o(busy2),
    .miss_count_o(mc2), .wb_count_o(wc2)
  );

  typedef struct {
    logic        rst, v, h, d;
    logic [31:0] ra, va;
    logic        st, wr, rd;
    logic [31:0] ma;
    logic        rf, bz;
    logic [31:0] mc, wc;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic r, v, h, d, input logic [31:0] ra, va,
                     input logic st, wr, rd, input logic [31:0] ma,
                     input logic rf, bz, input logic [31:0] mc, wc);
    vec_t e;
    e.rst = r; e.v = v; e.h = h; e.d = d; e.ra = ra; e.va = va;
    e.st = st; e.wr = wr; e.rd = rd; e.ma = ma; e.rf = rf; e.bz = bz; e.mc = mc; e.wc = wc;
    vt.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step2(input logic v, h, d);
    @(negedge clk);
    v2 = v; h2 = h; d2 = d;
    #1;
  endtask

  initial begin
    logic [100:0] got, exp;
    rst = 1'b1; req_valid = 1'b0; hit = 1'b0; victim_dirty = 1'b0;
    req_addr = 32'h0; victim_addr = 32'h0;
    v2 = 1'b0; h2 = 1'b0; d2 = 1'b0; ra2 = 32'h0000_4444; va2 = 32'h0000_8888;

    //   rst v  h  d  req_addr      victim_addr   st wr rd mem_addr      rf bz mc  wc
    add(1'b1,1'b0,1'b0,1'b0,32'h0,32'h0,         1'b0,1'b0,1'b0,32'h0,         1'b0,1'b0,32'd0,32'd0);
    for (int i = 0; i < 10; i++)
      add(1'b0,1'b1,1'b1,1'b0,32'h0000_1234,32'h0,1'b0,1'b0,1'b0,32'h0,       1'b0,1'b0,32'd0,32'd0);
    add(1'b0,1'b0,1'b0,1'b1,32'h0000_1234,32'h0,1'b0,1'b0,1'b0,32'h0,         1'b0,1'b0,32'd0,32'd0);
    // clean miss
    add(1'b0,1'b1,1'b0,1'b0,32'h0000_1234,32'h0,1'b1,1'b0,1'b0,32'h0,         1'b0,1'b0,32'd0,32'd0);
    add(1'b0,1'b1,1'b0,1'b0,32'h0000_1234,32'h0,1'b1,1'b0,1'b1,32'h0000_1230,1'b0,1'b1,32'd1,32'd0);
    add(1'b0,1'b1,1'b0,1'b0,32'h0000_1234,32'h0,1'b1,1'b0,1'b1,32'h0000_1230,1'b0,1'b1,32'd1,32'd0);
    add(1'b0,1'b1,1'b0,1'b0,32'h0000_1234,32'h0,1'b1,1'b0,1'b1,32'h0000_1230,1'b1,1'b1,32'd1,32'd0);
    add(1'b0,1'b1,1'b0,1'b0,32'h0000_1234,32'h0,1'b0,1'b0,1'b0,32'h0,         1'b0,1'b1,32'd1,32'd0);
    add(1'b0,1'b1,1'b1,1'b0,32'h0000_1234,32'h0,1'b0,1'b0,1'b0,32'h0,         1'b0,1'b0,32'd1,32'd0);
    // dirty miss, request/victim addresses change mid-writeback
    add(1'b0,1'b1,1'b0,1'b1,32'h0000_1010,32'h0000_2048,1'b1,1'b0,1'b0,32'h0,         1'b0,1'b0,32'd1,32'd0);
    add(1'b0,1'b1,1'b0,1'b1,32'h0000_1010,32'h0000_2048,1'b1,1'b1,1'b0,32'h0000_2040,1'b0,1'b1,32'd2,32'd0);
    add(1'b0,1'b1,1'b0,1'b1,32'h0000_5550,32'h0000_6660,1'b1,1'b0,1'b0,32'h0000_2040,1'b0,1'b1,32'd2,32'd1);
    add(1'b0,1'b1,1'b0,1'b1,32'h0000_5550,32'h0000_6660,1'b1,1'b0,1'b0,32'h0000_2040,1'b0,1'b1,32'd2,32'd1);
    add(1'b0,1'b1,1'b0,1'b1,32'h0000_5550,32'h0000_6660,1'b1,1'b0,1'b1,32'h0000_1010,1'b0,1'b1,32'd2,32'd1);
    add(1'b0,1'b1,1'b0,1'b1,32'h0000_5550,32'h0000_6660,1'b1,1'b0,1'b1,32'h0000_1010,1'b0,1'b1,32'd2,32'd1);
    add(1'b0,1'b1,1'b0,1'b1,32'h0000_5550,32'h0000_6660,1'b1,1'b0,1'b1,32'h0000_1010,1'b1,1'b1,32'd2,32'd1);
    add(1'b0,1'b1,1'b1,1'b0,32'h0000_5550,32'h0000_6660,1'b0,1'b0,1'b0,32'h0,         1'b0,1'b1,32'd2,32'd1);
    // back-to-back miss, then reset in its second refill cycle
    add(1'b0,1'b1,1'b0,1'b0,32'h0000_3ABC,32'h0,1'b1,1'b0,1'b0,32'h0,         1'b0,1'b0,32'd2,32'd1);
    add(1'b0,1'b1,1'b0,1'b0,32'h0000_7777,32'h0,1'b1,1'b0,1'b1,32'h0000_3AB0,1'b0,1'b1,32'd3,32'd1);
    add(1'b1,1'b1,1'b0,1'b0,32'h0000_7777,32'h0,1'b0,1'b0,1'b0,32'h0000_3AB0,1'b0,1'b1,32'd3,32'd1);
    add(1'b0,1'b0,1'b0,1'b0,32'h0000_7777,32'h0,1'b0,1'b0,1'b0,32'h0,         1'b0,1'b0,32'd0,32'd0);
    add(1'b0,1'b0,1'b0,1'b0,32'h0000_7777,32'h0,1'b0,1'b0,1'b0,32'h0,         1'b0,1'b0,32'd0,32'd0);
    add(1'b0,1'b0,1'b0,1'b0,32'h0000_7777,32'h0,1'b0,1'b0,1'b0,32'h0,         1'b0,1'b0,32'd0,32'd0);

    repeat (2) @(posedge clk);

    foreach (vt[i]) begin
      @(negedge clk);
      rst = vt[i].rst; req_valid = vt[i].v; hit = vt[i].h; victim_dirty = vt[i].d;
      req_addr = vt[i].ra; victim_addr = vt[i].va;
      #1;
      got = {stall, mem_wr_en, mem_rd_en, mem_addr, refill_en, busy, miss_count, wb_count};
      exp = {vt[i].st, vt[i].wr, vt[i].rd, vt[i].ma, vt[i].rf, vt[i].bz, vt[i].mc, vt[i].wc};
      n_vec++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL vec%0d: got st=%b wr=%b rd=%b ma=%h rf=%b bz=%b mc=%0d wc=%0d expected st=%b wr=%b rd=%b ma=%h rf=%b bz=%b mc=%0d wc=%0d",
                 i, stall, mem_wr_en, mem_rd_en, mem_addr, refill_en, busy, miss_count, wb_count,
                 vt[i].st, vt[i].wr, vt[i].rd, vt[i].ma, vt[i].rf, vt[i].bz, vt[i].mc, vt[i].wc);
      end
    end

    // Narrow counters with single-cycle latency: five clean misses saturate miss_count at 3
    for (int i = 0; i < 5; i++) begin
      step2(1'b1, 1'b0, 1'b0);
      chk("sat_idle_stall", {31'd0, stall2}, 32'd1);
      step2(1'b1, 1'b0, 1'b0);
      chk("sat_refill", {29'd0, rd2, rf2, wr2}, 32'b110);
      chk("sat_refill_addr", ma2, 32'h0000_4440);
      step2(1'b1, 1'b0, 1'b0);
      chk("sat_done_stall", {31'd0, stall2}, 32'd0);
      chk("sat_miss_count", {30'd0, mc2}, (i < 3) ? (i + 1) : 3);
    end
    step2(1'b1, 1'b0, 1'b1);
    chk("l1_dirty_stall", {31'd0, stall2}, 32'd1);
    step2(1'b1, 1'b0, 1'b1);
    chk("l1_wb", {29'd0, wr2, rd2, rf2}, 32'b100);
    chk("l1_wb_addr", ma2, 32'h0000_8880);
    step2(1'b1, 1'b0, 1'b1);
    chk("l1_refill", {29'd0, wr2, rd2, rf2}, 32'b011);
    chk("l1_wb_count", {30'd0, wc2}, 32'd1);
    step2(1'b0, 1'b0, 1'b0);
    chk("l1_done", {30'd0, stall2, busy2}, 32'b01);
    chk("l1_miss_sat", {30'd0, mc2}, 32'd3);
    step2(1'b0, 1'b0, 1'b0);
    chk("l1_idle_busy", {31'd0, busy2}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
